// File: rtl/mac_array_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_array_pipe                                                           |
// | LANES parallel multipliers, registered adder tree, saturating windowed   |
// | accumulator with valid/ready handshake and synchronous clear.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mac_array_pipe #(
   parameter int INPUT_BIT_WIDTH = 8,
   parameter int LANES           = 4,
   parameter int ACC_BIT_WIDTH   = 20
) (
   input  logic                               clk,
   input  logic                               layer_reset_n,
   input  logic                               acc_clear,
   input  logic                               signed_mode,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               in_last,
   input  logic [LANES*INPUT_BIT_WIDTH-1:0]   multiplicator,
   input  logic [LANES*INPUT_BIT_WIDTH-1:0]   multiplicand,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [ACC_BIT_WIDTH-1:0]           out_data,
   output logic                               out_ovf
);

   localparam int W      = INPUT_BIT_WIDTH;
   localparam int PROD_W = 2 * W;
   localparam int SUM_W  = PROD_W + $clog2(LANES);
   localparam int ACC_W  = ACC_BIT_WIDTH;
   localparam int EXT_W  = ACC_W + 1;

   logic                          stall;
   logic [LANES-1:0][PROD_W-1:0]  prod_d;
   logic [LANES-1:0][PROD_W-1:0]  s1_prod_q;
   logic                          s1_valid_q;
   logic                          s1_last_q;
   logic                          s1_mode_q;
   logic [SUM_W-1:0]              sum_d;
   logic [SUM_W-1:0]              s2_sum_q;
   logic                          s2_valid_q;
   logic                          s2_last_q;
   logic                          s2_mode_q;
   logic [EXT_W-1:0]              total;
   logic [ACC_W-1:0]              acc_d;
   logic [ACC_W-1:0]              acc_q;
   logic                          ovf_d;
   logic                          ovf_q;
   logic [ACC_W-1:0]              out_data_q;
   logic                          out_ovf_q;
   logic                          out_valid_q;

   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

   // Operands are widened to the product width first so the truncated product is exact.
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < LANES; i++) begin
         if (signed_mode) begin
            prod_d[i] = PROD_W'($signed(multiplicator[i*W +: W])) *
                        PROD_W'($signed(multiplicand[i*W +: W]));
         end else begin
            prod_d[i] = PROD_W'(multiplicator[i*W +: W]) *
                        PROD_W'(multiplicand[i*W +: W]);
         end
      end
   end

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_d = sum_d + (s1_mode_q ? SUM_W'($signed(s1_prod_q[i])) : SUM_W'(s1_prod_q[i]));
      end
   end

   // One guard bit above the accumulator detects overflow before clamping.
   always_comb begin
      if (s2_mode_q) begin
         total = EXT_W'($signed(acc_q)) + EXT_W'($signed(s2_sum_q));
      end else begin
         total = EXT_W'(acc_q) + EXT_W'(s2_sum_q);
      end
      acc_d = total[ACC_W-1:0];
      ovf_d = ovf_q;
      if (s2_mode_q) begin
         if (total[ACC_W] != total[ACC_W-1]) begin
            ovf_d = 1'b1;
            acc_d = total[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else if (total[ACC_W]) begin
         ovf_d = 1'b1;
         acc_d = '1;
      end
   end

   always_ff @(posedge clk or negedge layer_reset_n) begin
      if (!layer_reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_mode_q   <= 1'b0;
         s1_prod_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_mode_q   <= 1'b0;
         s2_sum_q    <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (acc_clear) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (!stall) begin
         s1_valid_q  <= in_valid;
         s1_last_q   <= in_last;
         s1_mode_q   <= signed_mode;
         s1_prod_q   <= prod_d;
         s2_valid_q  <= s1_valid_q;
         s2_last_q   <= s1_last_q;
         s2_mode_q   <= s1_mode_q;
         s2_sum_q    <= sum_d;
         // Not stalled means any presented result is consumed this edge.
         out_valid_q <= 1'b0;
         if (s2_valid_q) begin
            if (s2_last_q) begin
               out_data_q  <= acc_d;
               out_ovf_q   <= ovf_d;
               out_valid_q <= 1'b1;
               acc_q       <= '0;
               ovf_q       <= 1'b0;
            end else begin
               acc_q <= acc_d;
               ovf_q <= ovf_d;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mac_array_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mac_array_pipe                                                        |
// | Vector table, corner sequences and random traffic against a window model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mac_array_pipe;

   localparam int W = 8;
   localparam int L = 4;
   localparam int A = 20;

   logic          clk;
   logic          layer_reset_n;
   logic          acc_clear;
   logic          signed_mode;
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [L*W-1:0] multiplicator;
   logic [L*W-1:0] multiplicand;
   logic          out_valid;
   logic          out_ready;
   logic [A-1:0]  out_data;
   logic          out_ovf;

   mac_array_pipe #(
      .INPUT_BIT_WIDTH (W),
      .LANES           (L),
      .ACC_BIT_WIDTH   (A)
   ) dut (
      .clk           (clk),
      .layer_reset_n (layer_reset_n),
      .acc_clear     (acc_clear),
      .signed_mode   (signed_mode),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_last       (in_last),
      .multiplicator (multiplicator),
      .multiplicand  (multiplicand),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_ovf       (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- window-level reference model ----------------
   typedef struct packed {
      logic         o;
      logic [A-1:0] d;
   } res_t;

   res_t       exp_q[$];
   longint     m_acc;
   logic       m_ovf;
   logic       m_mode;
   logic       m_open;
   logic       have_prev;
   logic [A-1:0] prev_data;
   logic       prev_ovf;
   logic [7:0] m_a;
   logic [7:0] m_b;
   longint     m_s;
   res_t       m_r;

   initial begin
      m_acc = 0; m_ovf = 0; m_mode = 0; m_open = 0; have_prev = 0;
   end

   always @(negedge clk) begin
      #1;
      if (!layer_reset_n) begin
         exp_q.delete();
         m_open    = 0;
         have_prev = 0;
      end else begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
         if (have_prev) begin
            chk("stall_hold_data", {12'd0, out_data}, {12'd0, prev_data});
            chk("stall_hold_ovf", {31'd0, out_ovf}, {31'd0, prev_ovf});
         end
         have_prev = out_valid && !out_ready && !acc_clear;
         prev_data = out_data;
         prev_ovf  = out_ovf;
         if (acc_clear) begin
            exp_q.delete();
            m_open = 0;
         end else begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", 32'd1, 32'd0);
               end else begin
                  m_r = exp_q.pop_front();
                  chk("model_data", {12'd0, out_data}, {12'd0, m_r.d});
                  chk("model_ovf", {31'd0, out_ovf}, {31'd0, m_r.o});
               end
            end
            if (in_valid && in_ready) begin
               if (!m_open) begin
                  m_open = 1; m_mode = signed_mode; m_acc = 0; m_ovf = 0;
               end
               m_s = 0;
               for (int i = 0; i < L; i++) begin
                  m_a = multiplicator[i*W +: W];
                  m_b = multiplicand[i*W +: W];
                  if (m_mode) m_s += longint'($signed(m_a)) * longint'($signed(m_b));
                  else        m_s += longint'(m_a) * longint'(m_b);
               end
               m_acc += m_s;
               if (m_mode) begin
                  if (m_acc > 524287)       begin m_acc = 524287;  m_ovf = 1; end
                  else if (m_acc < -524288) begin m_acc = -524288; m_ovf = 1; end
               end else if (m_acc > 1048575) begin
                  m_acc = 1048575; m_ovf = 1;
               end
               if (in_last) begin
                  m_r.o = m_ovf;
                  m_r.d = m_acc[A-1:0];
                  exp_q.push_back(m_r);
                  m_open = 0;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input logic v, input logic l, input logic m,
                       input logic [7:0] a, input logic [7:0] b, input logic rdy);
      @(negedge clk);
      in_valid      = v;
      in_last       = l;
      signed_mode   = m;
      multiplicator = {L{a}};
      multiplicand  = {L{b}};
      out_ready     = rdy;
      acc_clear     = 1'b0;
   endtask

   task automatic wait_result(input logic rdy, output int lat, output logic ok);
      ok  = 1'b0;
      lat = -1;
      for (int k = 0; k < 12; k++) begin
         beat(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, rdy);
         #2;
         if (out_valid) begin
            ok  = 1'b1;
            lat = k;
            break;
         end
      end
      if (!ok) chk("result_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic         m;
      logic [7:0]   a;
      logic [7:0]   b;
      int           n;
      logic [A-1:0] d;
      logic         o;
   } vec_t;

   vec_t tbl[8];
   int   lat;
   logic ok;
   logic rmode;
   logic win_open;
   logic rv, rl, rr;

   initial begin
      tbl[0] = '{1'b0, 8'hFF, 8'hFF, 1, 20'h3F804, 1'b0};
      tbl[1] = '{1'b1, 8'h80, 8'h7F, 1, 20'hF0200, 1'b0};
      tbl[2] = '{1'b0, 8'hFF, 8'hFF, 5, 20'hFFFFF, 1'b1};
      tbl[3] = '{1'b0, 8'h01, 8'h01, 1, 20'h00004, 1'b0};
      tbl[4] = '{1'b0, 8'h02, 8'h03, 1, 20'h00018, 1'b0};
      tbl[5] = '{1'b1, 8'h7F, 8'h7F, 9, 20'h7FFFF, 1'b1};
      tbl[6] = '{1'b1, 8'h80, 8'h7F, 9, 20'h80000, 1'b1};
      tbl[7] = '{1'b1, 8'hFF, 8'h01, 1, 20'hFFFFC, 1'b0};

      layer_reset_n = 1'b1;
      acc_clear = 0; signed_mode = 0; in_valid = 0; in_last = 0;
      multiplicator = '0; multiplicand = '0; out_ready = 1'b1;
      #1 layer_reset_n = 1'b0;
      @(posedge clk); #2;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out_data", {12'd0, out_data}, 32'd0);
      chk("reset_out_ovf", {31'd0, out_ovf}, 32'd0);
      @(posedge clk); #3 layer_reset_n = 1'b1;
      #1 chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Table: each entry is a window of n identical beats
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < tbl[t].n; k++)
            beat(1'b1, k == tbl[t].n - 1, tbl[t].m, tbl[t].a, tbl[t].b, 1'b1);
         wait_result(1'b1, lat, ok);
         if (ok) begin
            chk($sformatf("tbl%0d_latency", t), lat, 32'd2);
            chk($sformatf("tbl%0d_data", t), {12'd0, out_data}, {12'd0, tbl[t].d});
            chk($sformatf("tbl%0d_ovf", t), {31'd0, out_ovf}, {31'd0, tbl[t].o});
         end
      end

      // Backpressure: result held while beats are offered
      beat(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
      wait_result(1'b0, lat, ok);
      for (int k = 0; k < 3; k++) begin
         beat(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0);
         #2;
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_data", {12'd0, out_data}, 32'h3F804);
      end
      beat(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1);
      beat(1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
      wait_result(1'b1, lat, ok);
      if (ok) chk("bp_next_data", {12'd0, out_data}, 32'd8);

      // acc_clear mid-window discards partial sum and the offered beat
      beat(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1);
      beat(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1);
      beat(1'b1, 1'b1, 1'b0, 8'd5, 8'd5, 1'b1);
      acc_clear = 1'b1;
      beat(1'b1, 1'b1, 1'b0, 8'd2, 8'd3, 1'b1);
      wait_result(1'b1, lat, ok);
      if (ok) begin
         chk("clr_latency", lat, 32'd2);
         chk("clr_data", {12'd0, out_data}, 32'd24);
      end

      // Asynchronous reset mid-window with a result still held
      beat(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
      wait_result(1'b0, lat, ok);
      beat(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1);
      beat(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1);
      #3;
      layer_reset_n = 1'b0;
      in_valid      = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out_data", {12'd0, out_data}, 32'd0);
      chk("arst_out_ovf", {31'd0, out_ovf}, 32'd0);
      @(negedge clk); #3 layer_reset_n = 1'b1;
      beat(1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
      wait_result(1'b1, lat, ok);
      if (ok) chk("arst_next_data", {12'd0, out_data}, 32'd4);

      // Random traffic checked by the model
      win_open = 1'b0;
      rmode    = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!win_open) rmode = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 3) != 0);
         rl = ($urandom_range(0, 3) == 0);
         rr = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         in_valid      = rv;
         in_last       = rl;
         signed_mode   = rmode;
         multiplicator = $urandom();
         multiplicand  = $urandom();
         out_ready     = rr;
         acc_clear     = 1'b0;
         #2;
         if (rv && in_ready) win_open = !rl;
      end
      if (win_open) beat(1'b1, 1'b1, rmode, 8'd3, 8'd7, 1'b1);
      for (int k = 0; k < 10; k++) beat(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
      #2;
      chk("drain_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
